// File: rtl/register_file.sv
// Architectural register file with rename tags for an out-of-order core.
// Each entry holds a committed value and the RoB tag of its youngest in-flight producer.
module register_file #(
   parameter int                    REG_WIDTH    = 5,
   parameter int                    EX_REG_WIDTH = 6,
   parameter logic [EX_REG_WIDTH-1:0] NON_REG    = 6'b100000,
   parameter int                    RoB_WIDTH    = 8,
   parameter int                    EX_RoB_WIDTH = 9,
   parameter logic [EX_RoB_WIDTH-1:0] NON_DEP    = 9'b100000000
) (
   input  logic                    Sys_clk,
   input  logic                    Sys_rst,
   input  logic                    Sys_rdy,
   input  logic                    DPRF_en,
   input  logic [EX_REG_WIDTH-1:0] DPRF_rs1,
   input  logic [EX_REG_WIDTH-1:0] DPRF_rs2,
   input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
   input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
   output logic [31:0]             RFDP_Vj,
   output logic [31:0]             RFDP_Vk,
   output logic [EX_RoB_WIDTH-1:0] RFDP_Qj,
   output logic [EX_RoB_WIDTH-1:0] RFDP_Qk,
   input  logic                    RoBRF_en,
   input  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
   input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
   input  logic [31:0]             RoBRF_value,
   input  logic                    RoBRF_flush
);

   localparam int NUM_REGS = 1 << REG_WIDTH;

   logic [31:0]             value_q [NUM_REGS];
   logic [EX_RoB_WIDTH-1:0] tag_q   [NUM_REGS];

   logic [EX_RoB_WIDTH-1:0] commit_tag;
   logic [EX_RoB_WIDTH-1:0] rename_tag;
   logic [REG_WIDTH-1:0]    commit_idx;
   logic [REG_WIDTH-1:0]    rename_idx;
   logic                    commit_wr;
   logic                    rename_wr;

   // x0 and the "no register" encodings are never written.
   function automatic logic rd_valid(input logic [EX_REG_WIDTH-1:0] rd);
      return (rd != NON_REG) && !rd[EX_REG_WIDTH-1] && (rd[REG_WIDTH-1:0] != '0);
   endfunction

   // Returns {V, Q}; a commit to the same register with a matching tag is forwarded.
   function automatic logic [32+EX_RoB_WIDTH-1:0] read_port(input logic [EX_REG_WIDTH-1:0] rs);
      logic [REG_WIDTH-1:0] idx;
      idx = rs[REG_WIDTH-1:0];
      if (!rd_valid(rs))
         return {32'd0, NON_DEP};
      else if (RoBRF_en && (RoBRF_rd == rs) && (tag_q[idx] == commit_tag))
         return {RoBRF_value, NON_DEP};
      else
         return {value_q[idx], tag_q[idx]};
   endfunction

   assign commit_tag = {1'b0, RoBRF_RoB_index};
   assign rename_tag = {1'b0, DPRF_RoB_index};
   assign commit_idx = RoBRF_rd[REG_WIDTH-1:0];
   assign rename_idx = DPRF_rd[REG_WIDTH-1:0];
   assign commit_wr  = RoBRF_en && rd_valid(RoBRF_rd);
   assign rename_wr  = DPRF_en && rd_valid(DPRF_rd);

   assign {RFDP_Vj, RFDP_Qj} = read_port(DPRF_rs1);
   assign {RFDP_Vk, RFDP_Qk} = read_port(DPRF_rs2);

   // Later assignments win: flush beats both tag updates, rename beats commit.
   always_ff @(posedge Sys_clk) begin
      if (Sys_rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= NON_DEP;
         end
      end else if (Sys_rdy) begin
         if (commit_wr) begin
            value_q[commit_idx] <= RoBRF_value;
            if (tag_q[commit_idx] == commit_tag)
               tag_q[commit_idx] <= NON_DEP;
         end
         if (RoBRF_flush) begin
            for (int i = 0; i < NUM_REGS; i++)
               tag_q[i] <= NON_DEP;
         end else if (rename_wr) begin
            tag_q[rename_idx] <= rename_tag;
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a vector table of per-cycle stimulus and
// expected combinational reads, followed by a mid-operation reset sequence.
module tb_register_file;

   localparam logic [5:0] NR = 6'b100000;
   localparam logic [8:0] ND = 9'b100000000;

   logic        Sys_clk = 1'b0;
   logic        Sys_rst, Sys_rdy;
   logic        DPRF_en;
   logic [5:0]  DPRF_rs1, DPRF_rs2, DPRF_rd;
   logic [7:0]  DPRF_RoB_index;
   logic [31:0] RFDP_Vj, RFDP_Vk;
   logic [8:0]  RFDP_Qj, RFDP_Qk;
   logic        RoBRF_en;
   logic [7:0]  RoBRF_RoB_index;
   logic [5:0]  RoBRF_rd;
   logic [31:0] RoBRF_value;
   logic        RoBRF_flush;

   int checks = 0;
   int failures = 0;

   register_file dut (
      .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
      .DPRF_en(DPRF_en), .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2),
      .DPRF_rd(DPRF_rd), .DPRF_RoB_index(DPRF_RoB_index),
      .RFDP_Vj(RFDP_Vj), .RFDP_Vk(RFDP_Vk), .RFDP_Qj(RFDP_Qj), .RFDP_Qk(RFDP_Qk),
      .RoBRF_en(RoBRF_en), .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_rd(RoBRF_rd),
      .RoBRF_value(RoBRF_value), .RoBRF_flush(RoBRF_flush)
   );

   always #5 Sys_clk = ~Sys_clk;

   typedef struct {
      logic        rdy;
      logic        dp_en;
      logic [5:0]  rd;
      logic [7:0]  dp_idx;
      logic        c_en;
      logic [5:0]  c_rd;
      logic [7:0]  c_idx;
      logic [31:0] c_val;
      logic        flush;
      logic [5:0]  rs1, rs2;
      logic [31:0] vj;
      logic [8:0]  qj;
      logic [31:0] vk;
      logic [8:0]  qk;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rdy, logic dp_en, logic [5:0] rd, logic [7:0] dp_idx,
                               logic c_en, logic [5:0] c_rd, logic [7:0] c_idx, logic [31:0] c_val,
                               logic flush, logic [5:0] rs1, logic [5:0] rs2,
                               logic [31:0] vj, logic [8:0] qj, logic [31:0] vk, logic [8:0] qk);
      vec_t v;
      v.rdy = rdy; v.dp_en = dp_en; v.rd = rd; v.dp_idx = dp_idx;
      v.c_en = c_en; v.c_rd = c_rd; v.c_idx = c_idx; v.c_val = c_val;
      v.flush = flush; v.rs1 = rs1; v.rs2 = rs2;
      v.vj = vj; v.qj = qj; v.vk = vk; v.qk = qk;
      return v;
   endfunction

   task automatic drive_idle();
      Sys_rdy = 1'b1; DPRF_en = 1'b0; DPRF_rd = NR; DPRF_RoB_index = '0;
      RoBRF_en = 1'b0; RoBRF_rd = NR; RoBRF_RoB_index = '0; RoBRF_value = '0;
      RoBRF_flush = 1'b0; DPRF_rs1 = NR; DPRF_rs2 = NR;
   endtask

   task automatic cycle();
      @(posedge Sys_clk);
      #1;
   endtask

   task automatic check(string name, logic [31:0] vj, logic [8:0] qj, logic [31:0] vk, logic [8:0] qk);
      checks++;
      if (RFDP_Vj !== vj || RFDP_Qj !== qj || RFDP_Vk !== vk || RFDP_Qk !== qk) begin
         failures++;
         $display("FAIL %s: got Vj=%h Qj=%h Vk=%h Qk=%h, expected Vj=%h Qj=%h Vk=%h Qk=%h",
                  name, RFDP_Vj, RFDP_Qj, RFDP_Vk, RFDP_Qk, vj, qj, vk, qk);
      end
   endtask

   initial begin
      //           rdy en rd  didx cen crd cidx  cval        fl rs1 rs2  vj          qj      vk          qk
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 5,  NR, 0,          ND,     0,          ND));
      vecs.push_back(mk(1, 1, 3,  7,   0, NR, 0,   0,          0, 3,  0,  0,          ND,     0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 3,  NR, 0,          9'd7,   0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   1, 3,  7,   32'h1234,   0, 3,  NR, 32'h1234,   ND,     0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 3,  3,  32'h1234,   ND,     32'h1234,   ND));
      vecs.push_back(mk(1, 1, 4,  2,   0, NR, 0,   0,          0, 4,  NR, 0,          ND,     0,          ND));
      vecs.push_back(mk(1, 1, 4,  9,   0, NR, 0,   0,          0, 4,  NR, 0,          9'd2,   0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   1, 4,  2,   32'hAA,     0, 4,  NR, 0,          9'd9,   0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 4,  NR, 32'hAA,     9'd9,   0,          ND));
      vecs.push_back(mk(1, 1, 6,  1,   0, NR, 0,   0,          0, 6,  NR, 0,          ND,     0,          ND));
      vecs.push_back(mk(1, 1, 6,  12,  1, 6,  1,   32'h66,     0, 6,  6,  32'h66,     ND,     32'h66,     ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 6,  NR, 32'h66,     9'd12,  0,          ND));
      vecs.push_back(mk(1, 1, 1,  3,   0, NR, 0,   0,          0, 1,  NR, 0,          ND,     0,          ND));
      vecs.push_back(mk(1, 1, 2,  4,   0, NR, 0,   0,          0, 1,  NR, 0,          9'd3,   0,          ND));
      vecs.push_back(mk(1, 1, 5,  5,   0, NR, 0,   0,          1, 1,  2,  0,          9'd3,   0,          9'd4));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 1,  2,  0,          ND,     0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 5,  4,  0,          ND,     32'hAA,     ND));
      vecs.push_back(mk(1, 1, 0,  11,  1, 0,  0,   32'hFFFF,   0, 0,  6,  0,          ND,     32'h66,     ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 0,  NR, 0,          ND,     0,          ND));
      vecs.push_back(mk(0, 1, 7,  20,  1, 6,  0,   32'hBEEF,   0, 7,  6,  0,          ND,     32'h66,     ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 7,  6,  0,          ND,     32'h66,     ND));
      vecs.push_back(mk(1, 1, 8,  30,  0, NR, 0,   0,          0, 8,  NR, 0,          ND,     0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   1, 8,  30,  32'h88,     1, 8,  NR, 32'h88,     ND,     0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 8,  NR, 32'h88,     ND,     0,          ND));
      vecs.push_back(mk(1, 1, 9,  255, 0, NR, 0,   0,          0, 9,  NR, 0,          ND,     0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   1, 9,  127, 32'h99,     0, 9,  NR, 0,          9'h0FF, 0,          ND));
      vecs.push_back(mk(1, 0, NR, 0,   0, NR, 0,   0,          0, 9,  NR, 32'h99,     9'h0FF, 0,          ND));

      drive_idle();
      Sys_rst = 1'b1;
      cycle();
      cycle();
      Sys_rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         Sys_rdy = vecs[i].rdy;
         DPRF_en = vecs[i].dp_en; DPRF_rd = vecs[i].rd; DPRF_RoB_index = vecs[i].dp_idx;
         RoBRF_en = vecs[i].c_en; RoBRF_rd = vecs[i].c_rd; RoBRF_RoB_index = vecs[i].c_idx;
         RoBRF_value = vecs[i].c_val; RoBRF_flush = vecs[i].flush;
         DPRF_rs1 = vecs[i].rs1; DPRF_rs2 = vecs[i].rs2;
         #2;
         check($sformatf("vec%0d", i), vecs[i].vj, vecs[i].qj, vecs[i].vk, vecs[i].qk);
         cycle();
      end

      // Reset during activity: pending renames and a same-edge commit/rename are dropped.
      drive_idle();
      DPRF_en = 1'b1; DPRF_rd = 6'd10; DPRF_RoB_index = 8'd5;
      cycle();
      drive_idle();
      DPRF_rs1 = 6'd10; DPRF_rs2 = 6'd9;
      #2;
      check("pre_reset_rename", 32'd0, 9'd5, 32'h99, 9'h0FF);
      Sys_rst = 1'b1;
      DPRF_en = 1'b1; DPRF_rd = 6'd11; DPRF_RoB_index = 8'd6;
      RoBRF_en = 1'b1; RoBRF_rd = 6'd9; RoBRF_RoB_index = 8'hFF; RoBRF_value = 32'h5;
      RoBRF_flush = 1'b1;
      cycle();
      Sys_rst = 1'b0;
      drive_idle();
      DPRF_rs1 = 6'd10; DPRF_rs2 = 6'd9;
      #2;
      check("post_reset_10_9", 32'd0, ND, 32'd0, ND);
      DPRF_rs1 = 6'd11; DPRF_rs2 = 6'd3;
      #2;
      check("post_reset_11_3", 32'd0, ND, 32'd0, ND);
      DPRF_rs1 = 6'd4; DPRF_rs2 = 6'd6;
      #2;
      check("post_reset_4_6", 32'd0, ND, 32'd0, ND);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Parameters
REQ-001 SHALL declare parameters: REG_WIDTH, default 5, architectural register index width.
REQ-002 SHALL declare: EX_REG_WIDTH, default 6, register index plus "no register" bit.
REQ-003 SHALL declare: NON_REG, default 6'b100000, "no register" encoding.
REQ-004 SHALL declare: RoB_WIDTH, default 8, RoB index width.
REQ-005 SHALL declare: EX_RoB_WIDTH, default 9, RoB index plus "no dependency" bit.
REQ-006 SHALL declare: NON_DEP, default 9'b100000000, "no dependency" encoding.

Interface (clock and reset first)
REQ-007 SHALL have: Sys_clk  in  1  single clock, all state updates on rising edge.
REQ-008 SHALL have: Sys_rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have: Sys_rdy  in  1  state updates only when high; reset overrides it.
REQ-010 SHALL have: DPRF_en  in  1  dispatch of a new instruction this cycle.
REQ-011 SHALL have: DPRF_rs1, DPRF_rs2  in  EX_REG_WIDTH  source registers, NON_REG = unused.
REQ-012 SHALL have: DPRF_rd  in  EX_REG_WIDTH  destination register, NON_REG = none.
REQ-013 SHALL have: DPRF_RoB_index  in  RoB_WIDTH  RoB entry allocated to the dispatched instruction.
REQ-014 SHALL have: RFDP_Vj, RFDP_Vk  out  32  source values.
REQ-015 SHALL have: RFDP_Qj, RFDP_Qk  out  EX_RoB_WIDTH  producer tags, NON_DEP = value valid.
REQ-016 SHALL have: RoBRF_en  in  1  commit pulse.
REQ-017 SHALL have: RoBRF_RoB_index  in  RoB_WIDTH  index of the committing entry.
REQ-018 SHALL have: RoBRF_rd  in  EX_REG_WIDTH  commit destination register.
REQ-019 SHALL have: RoBRF_value  in  32  commit value.
REQ-020 SHALL have: RoBRF_flush  in  1  mispredict pulse, discard all rename state.

Function
REQ-021 SHALL hold 32 entries, each a 32-bit value plus an EX_RoB_WIDTH tag.
REQ-022 Reads SHALL be combinational on DPRF_rs1/rs2, independent of DPRF_en.
REQ-023 Read rule: rs == NON_REG or rs == 0 -> V=0, Q=NON_DEP.
REQ-024 Read rule, otherwise: V = value[rs], Q = tag[rs].
REQ-025 Commit bypass: RoBRF_en, RoBRF_rd == rs, and tag[rs] == {0,RoBRF_RoB_index} in the same cycle -> V=RoBRF_value, Q=NON_DEP.
REQ-026 Reads SHALL return pre-rename state; an instruction whose rs equals its own rd sees the old producer.
REQ-027 Commit (RoBRF_en, rd not NON_REG, rd != 0): value[rd] <= RoBRF_value.
REQ-028 Commit SHALL also set tag[rd] <= NON_DEP, only when tag[rd] == {0,RoBRF_RoB_index}; otherwise the tag is kept (a younger producer exists).
REQ-029 Rename (DPRF_en, rd not NON_REG, rd != 0, no flush): tag[rd] <= {0,DPRF_RoB_index}.
REQ-030 Same-cycle commit and rename of one rd: value is written, and the rename tag wins.
REQ-031 Flush: every tag <= NON_DEP; a same-cycle rename is discarded; a same-cycle commit value is still written.
REQ-032 x0 SHALL never change: value 0, tag NON_DEP.
REQ-033 With Sys_rdy low: no state change, and reads stay valid.
REQ-034 RoB index wrap-around SHALL need no special handling; tags compare on the full index only.

Reset
REQ-035 Sys_rst high at a rising edge SHALL set all values to 0 and all tags to NON_DEP, overriding commit, rename and flush.
REQ-036 After reset, any read SHALL give V=0 and Q=NON_DEP.
REQ-037 Reset mid-operation SHALL drop all pending renames.

Verification
REQ-038 Reset, read rs1=5, rs2=NON_REG -> Vj=0, Qj=NON_DEP; Vk=0, Qk=NON_DEP.
REQ-039 Rename x3 to RoB 7, then read x3 -> Qj=7; commit rd=3 idx=7 val=0x1234 -> same-cycle read Vj=0x1234, Qj=NON_DEP, next cycle identical.
REQ-040 Rename x4->RoB 2, rename x4->RoB 9, commit rd=4 idx=2 val=0xAA -> value[4]=0xAA, Q stays 9.
REQ-041 Same cycle: commit rd=6 idx=1 (tag 1) and rename rd=6 to 12 -> value updated, tag=12; read of rs1=6 in that cycle -> bypass value, Q=NON_DEP.
REQ-042 Rename x1,x2 to 3,4; flush in the same cycle as rename x5->5 -> all Q=NON_DEP, x5 not renamed.
REQ-043 Rename or commit to x0 with value 0xFFFF -> x0 reads V=0, Q=NON_DEP.
